// File: rtl/rlm_pkg.sv
// Shared types and constants for the run-length monitor.
package rlm_pkg;

  localparam int RLM_CNT_W_DEF = 8;
  localparam int RLM_DROP_W    = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rlm_state_e;

  // Saturating increment for the drop counter
  function automatic logic [RLM_DROP_W-1:0] drop_inc(input logic [RLM_DROP_W-1:0] v);
    if (v == {RLM_DROP_W{1'b1}}) begin
      drop_inc = v;
    end else begin
      drop_inc = v + {{(RLM_DROP_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/rlm_out_reg.sv
// Single-entry valid/ready report register; counts captures lost while full.
module rlm_out_reg
  import rlm_pkg::*;
#(
  parameter int CNT_W = RLM_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cap_valid,
  input  logic [CNT_W-1:0]      cap_len,
  input  logic                  cap_sat,
  input  logic                  rpt_ready,
  output logic                  rpt_valid,
  output logic [CNT_W-1:0]      rpt_len,
  output logic                  rpt_sat,
  output logic [RLM_DROP_W-1:0] drop_cnt
);

  logic                  valid_r;
  logic [CNT_W-1:0]      len_r;
  logic                  sat_r;
  logic [RLM_DROP_W-1:0] drop_r;

  // Load on capture when empty or draining, otherwise drop; clear on a plain transfer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_r <= 1'b0;
      len_r   <= {CNT_W{1'b0}};
      sat_r   <= 1'b0;
      drop_r  <= {RLM_DROP_W{1'b0}};
    end else begin
      if (cap_valid) begin
        if (!valid_r || rpt_ready) begin
          valid_r <= 1'b1;
          len_r   <= cap_len;
          sat_r   <= cap_sat;
        end else begin
          drop_r  <= drop_inc(drop_r);
        end
      end else if (valid_r && rpt_ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign rpt_valid = valid_r;
  assign rpt_len   = len_r;
  assign rpt_sat   = sat_r;
  assign drop_cnt  = drop_r;

endmodule

// File: rtl/run_length_monitor.sv
// Measures the length of each high run on `in` and reports it through a holding register.
// Optional feature: define RLM_MAX_TRACK_EN to add the max_len output.
module run_length_monitor
  import rlm_pkg::*;
#(
  parameter int CNT_W = RLM_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in,
  input  logic                  rpt_ready,
  output logic                  rpt_valid,
  output logic [CNT_W-1:0]      rpt_len,
  output logic                  rpt_sat,
  output logic [RLM_DROP_W-1:0] drop_cnt
`ifdef RLM_MAX_TRACK_EN
  ,
  output logic [CNT_W-1:0]      max_len
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  rlm_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] run_cnt_r, cnt_nxt_s;
  logic             sat_r, sat_nxt_s;
  logic             capture_s;

  // Run FSM next-state; the counter holds at its maximum instead of wrapping
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = run_cnt_r;
    sat_nxt_s   = sat_r;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = CNT_ONE;
          sat_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (in) begin
          if (run_cnt_r != CNT_MAX) begin
            cnt_nxt_s = run_cnt_r + CNT_ONE;
          end else begin
            cnt_nxt_s = run_cnt_r;
          end
          sat_nxt_s = sat_r | (run_cnt_r >= (CNT_MAX - CNT_ONE));
        end else begin
          capture_s   = 1'b1;
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
        sat_nxt_s   = 1'b0;
      end
    endcase
  end

  // Run FSM state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= IDLE;
      run_cnt_r <= {CNT_W{1'b0}};
      sat_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      run_cnt_r <= cnt_nxt_s;
      sat_r     <= sat_nxt_s;
    end
  end

  rlm_out_reg #(
    .CNT_W (CNT_W)
  ) u_out_reg (
    .clk       (clk),
    .rstn      (rstn),
    .cap_valid (capture_s),
    .cap_len   (run_cnt_r),
    .cap_sat   (sat_r),
    .rpt_ready (rpt_ready),
    .rpt_valid (rpt_valid),
    .rpt_len   (rpt_len),
    .rpt_sat   (rpt_sat),
    .drop_cnt  (drop_cnt)
  );

`ifdef RLM_MAX_TRACK_EN
  logic [CNT_W-1:0] max_len_r;

  // Largest captured length, dropped reports included
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      max_len_r <= {CNT_W{1'b0}};
    end else if (capture_s && (run_cnt_r > max_len_r)) begin
      max_len_r <= run_cnt_r;
    end
  end

  assign max_len = max_len_r;
`endif

endmodule

// File: tb/tb_run_length_monitor.sv
// Self-checking bench for run_length_monitor (CNT_W=4) with a cycle-level reference model.
module tb_run_length_monitor;

  localparam int LEN_W = 4;
  localparam int LMAX  = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             rstn;
  logic             in;
  logic             rpt_ready;
  logic             rpt_valid;
  logic [LEN_W-1:0] rpt_len;
  logic             rpt_sat;
  logic [7:0]       drop_cnt;
`ifdef RLM_MAX_TRACK_EN
  logic [LEN_W-1:0] max_len;
`endif

  int n_vec = 0;
  int n_err = 0;

  // reference model state: plain counts, not the RTL encoding
  int m_run, m_len, m_drop, m_max;
  bit m_valid, m_sat;

  run_length_monitor #(.CNT_W(LEN_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in        (in),
    .rpt_ready (rpt_ready),
    .rpt_valid (rpt_valid),
    .rpt_len   (rpt_len),
    .rpt_sat   (rpt_sat),
    .drop_cnt  (drop_cnt)
`ifdef RLM_MAX_TRACK_EN
    ,
    .max_len   (max_len)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_run = 0; m_len = 0; m_drop = 0; m_max = 0; m_valid = 0; m_sat = 0;
  endtask

  // Drive one cycle of inputs, advance the model on the edge, settle 1 time unit
  task automatic step(input logic i_v, input logic r_v);
    int rep;
    in = i_v;
    rpt_ready = r_v;
    @(posedge clk);
    rep = (m_run > LMAX) ? LMAX : m_run;
    if (m_run > 0 && !i_v) begin
      if (rep > m_max) m_max = rep;
      if (!m_valid || r_v) begin
        m_valid = 1; m_len = rep; m_sat = (m_run >= LMAX);
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end else if (m_valid && r_v) begin
      m_valid = 0;
    end
    m_run = i_v ? m_run + 1 : 0;
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_clear();
    n_vec++;
    if (rpt_valid !== 1'b0 || rpt_len !== 4'd0 || rpt_sat !== 1'b0 || drop_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_outputs valid=%b len=%0d sat=%b drop=%0d required all 0",
               rpt_valid, rpt_len, rpt_sat, drop_cnt);
    end
`ifdef RLM_MAX_TRACK_EN
    n_vec++;
    if (max_len !== 4'd0) begin
      n_err++;
      $display("FAIL reset_max got %0d required 0", max_len);
    end
`endif
    @(posedge clk);
    @(posedge clk);
    #3 rstn = 1'b1;
  endtask

  task automatic test_reset();
    in = 1'b0;
    rpt_ready = 1'b0;
    do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    n_vec++;
    if (rpt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_report got %b required 0", rpt_valid);
    end
  endtask

  task automatic test_basic_run();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    n_vec++;
    if (rpt_valid !== 1'b1 || rpt_len !== 4'd5 || rpt_sat !== 1'b0) begin
      n_err++;
      $display("FAIL run5 valid=%b len=%0d sat=%b required 1/5/0", rpt_valid, rpt_len, rpt_sat);
    end
    step(1'b0, 1'b1);
    n_vec++;
    if (rpt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL run5_drain got %b required 0", rpt_valid);
    end
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    n_vec++;
    if (rpt_valid !== 1'b1 || rpt_len !== 4'd1) begin
      n_err++;
      $display("FAIL pulse1 valid=%b len=%0d required 1/1", rpt_valid, rpt_len);
    end
    step(1'b0, 1'b1);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    n_vec++;
    if (rpt_valid !== 1'b1 || rpt_len !== 4'd15 || rpt_sat !== 1'b1) begin
      n_err++;
      $display("FAIL sat20 valid=%b len=%0d sat=%b required 1/15/1", rpt_valid, rpt_len, rpt_sat);
    end
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    n_vec++;
    if (rpt_len !== 4'd14 || rpt_sat !== 1'b0) begin
      n_err++;
      $display("FAIL run14 len=%0d sat=%b required 14/0", rpt_len, rpt_sat);
    end
    step(1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n_vec++;
    if (rpt_valid !== 1'b1 || rpt_len !== 4'd3 || drop_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL b2b_drop valid=%b len=%0d drop=%0d required 1/3/1", rpt_valid, rpt_len, drop_cnt);
    end
    step(1'b0, 1'b1);
    n_vec++;
    if (rpt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain got %b required 0", rpt_valid);
    end
  endtask

  task automatic test_capture_with_transfer();
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    n_vec++;
    if (rpt_valid !== 1'b1 || rpt_len !== 4'd2 || drop_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL cap_xfer valid=%b len=%0d drop=%0d required 1/2/0", rpt_valid, rpt_len, drop_cnt);
    end
    step(1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    in = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    n_vec++;
    if (rpt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL partial_discard got %b required 0", rpt_valid);
    end
    step(1'b0, 1'b1);
    n_vec++;
    if (rpt_valid !== 1'b1 || rpt_len !== 4'd6) begin
      n_err++;
      $display("FAIL post_reset_run valid=%b len=%0d required 1/6", rpt_valid, rpt_len);
    end
    step(1'b0, 1'b1);
  endtask

  task automatic test_drop_saturation();
    do_reset();
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    n_vec++;
    if (drop_cnt !== 8'd255 || rpt_len !== 4'd1 || rpt_valid !== 1'b1) begin
      n_err++;
      $display("FAIL drop_sat drop=%0d len=%0d valid=%b required 255/1/1", drop_cnt, rpt_len, rpt_valid);
    end
  endtask

`ifdef RLM_MAX_TRACK_EN
  task automatic test_max_track();
    int runs[3] = '{4, 9, 2};
    int exp_max[3] = '{4, 9, 9};
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < runs[r]; i++) step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      n_vec++;
      if (max_len !== LEN_W'(exp_max[r])) begin
        n_err++;
        $display("FAIL max_len run%0d got %0d required %0d", r, max_len, exp_max[r]);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic cur = 1'b0;
    logic rdy;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) cur = ~cur;
      rdy = ($urandom_range(0, 2) != 0);
      step(cur, rdy);
      n_vec++;
      if (rpt_valid !== m_valid || rpt_len !== LEN_W'(m_len) || rpt_sat !== m_sat ||
          drop_cnt !== 8'(m_drop)) begin
        n_err++;
        $display("FAIL rand cyc%0d valid=%b len=%0d sat=%b drop=%0d required %b/%0d/%b/%0d",
                 c, rpt_valid, rpt_len, rpt_sat, drop_cnt, m_valid, m_len, m_sat, m_drop);
      end
`ifdef RLM_MAX_TRACK_EN
      n_vec++;
      if (max_len !== LEN_W'(m_max)) begin
        n_err++;
        $display("FAIL rand_max cyc%0d got %0d required %0d", c, max_len, m_max);
      end
`endif
    end
  endtask

  initial begin
    rstn = 1'b0;
    in = 1'b0;
    rpt_ready = 1'b0;
    model_clear();
    test_reset();
    test_basic_run();
    test_saturation();
    test_back_to_back();
    test_capture_with_transfer();
    test_reset_mid_run();
    test_drop_saturation();
`ifdef RLM_MAX_TRACK_EN
    test_max_track();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/run_length_monitor.md
RUN_LENGTH_MONITOR -- requirements
Module: run_length_monitor

Interface
REQ-001 The block SHALL be parameterised as: CNT_W, default 8, width of the run-length counter and of the report.
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port: rstn  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port: in  input  1  level flag from the upstream classifier FSM, synchronous to clk.
REQ-005 The block SHALL have port: rpt_ready  input  1  consumer accepts the report.
REQ-006 The block SHALL have port: rpt_valid  output  1  report available.
REQ-007 The block SHALL have port: rpt_len  output  CNT_W  length, in cycles, of the completed high run.
REQ-008 The block SHALL have port: rpt_sat  output  1  the reported run reached the saturation value.
REQ-009 The block SHALL have port: drop_cnt  output  8  number of reports lost to back-pressure, saturating.

Function
REQ-010 The run FSM SHALL have two states: IDLE (in low) and RUN (counting).
REQ-011 In IDLE with in=1, the FSM SHALL load run_cnt=1, clear the sat flag and go to RUN.
REQ-012 In IDLE with in=0, the FSM SHALL stay in IDLE and leave run_cnt unchanged.
REQ-013 In RUN with in=1, run_cnt SHALL increment; at 2^CNT_W-1 it SHALL hold (no wrap) and set the sat flag.
REQ-014 In RUN with in=0, the FSM SHALL raise a capture of {run_cnt, sat} and go to IDLE.
REQ-015 A high run of N sampled cycles SHALL report rpt_len=min(N, 2^CNT_W-1).
REQ-016 rpt_valid SHALL rise on the clock edge after the cycle in which in is first sampled low; latency is 1 cycle.
REQ-017 The output register SHALL be a single-entry valid/ready holding register.
REQ-018 A transfer SHALL occur when rpt_valid=1 and rpt_ready=1.
REQ-019 rpt_len and rpt_sat SHALL be stable while rpt_valid=1 and no transfer has occurred.
REQ-020 Capture while empty: the register SHALL load and set rpt_valid.
REQ-021 Capture and transfer in the same cycle: the new report SHALL load and rpt_valid SHALL stay 1.
REQ-022 Capture while full with rpt_ready=0: the new report SHALL be discarded, the held report kept, and drop_cnt incremented, saturating at 255.
REQ-023 Transfer with no capture: rpt_valid SHALL clear.
REQ-024 A single-cycle pulse on in SHALL report rpt_len=1.
REQ-025 Back-to-back runs separated by one low cycle SHALL each be reported or dropped independently.

Reset
REQ-026 Reset assertion SHALL immediately force: state=IDLE, run_cnt=0, sat=0, rpt_valid=0, rpt_len=0, rpt_sat=0, drop_cnt=0.
REQ-027 Reset during RUN SHALL discard the partial run; no report SHALL be produced for it.
REQ-028 If in=1 on the first edge after reset release, that edge SHALL start a new run with run_cnt=1.

Configuration
REQ-029 With RLM_MAX_TRACK_EN defined, the block SHALL add output max_len (CNT_W).
REQ-030 With RLM_MAX_TRACK_EN defined, max_len SHALL hold the largest captured run length since reset, including dropped runs; it SHALL update on the capture edge and reset to 0.
REQ-031 With RLM_MAX_TRACK_EN undefined, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 Package rlm_pkg SHALL hold the run-state enum (IDLE, RUN), the default CNT_W and the drop-counter width constant (8).
REQ-033 The sub-module rlm_out_reg SHALL implement the single-entry valid/ready holding register, including the drop indication; run_length_monitor SHALL instantiate it once.

Verification
REQ-034 Scenario: rstn low; in=1 for 5 cycles, then 0; rpt_ready=1 -> rpt_valid for 1 cycle, rpt_len=5, rpt_sat=0.
REQ-035 Scenario: CNT_W=4, in=1 for 20 cycles, then 0 -> rpt_len=15, rpt_sat=1.
REQ-036 Scenario: rpt_ready=0; runs of 3 and 4 cycles separated by 1 low cycle -> rpt_len=3 held, drop_cnt=1; after rpt_ready=1, one transfer of 3, then rpt_valid=0.
REQ-037 Scenario: report pending, rpt_ready=1 in the same cycle as the capture of a 2-cycle run -> first report accepted, rpt_len=2, rpt_valid stays 1.
REQ-038 Scenario: rstn asserted on cycle 3 of a run, in held high -> all outputs 0; after release, a run of 6 cycles reports 6.
REQ-039 Scenario: RLM_MAX_TRACK_EN defined; runs of 4, 9 and 2 cycles -> max_len sequence 4, 9, 9.
